// File: rtl/jogador_automatico.sv
// rtl/jogador_automatico.sv - automatic player: captures the game's LED sequence and replays it on botoes
// Capture runs ESPERA/LED_ON/LED_OFF; replay runs PRESSIONA/SOLTA/FIM with programmable timing.
module jogador_automatico #(
  parameter int MAX_SEQ      = 16,
  parameter int HOLD_CYCLES  = 500,
  parameter int GAP_CYCLES   = 250,
  parameter int QUIET_CYCLES = 2000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         iniciar,
  input  logic                         parar,
  input  logic                         modo_erro,
  input  logic [3:0]                   leds,
  output logic [3:0]                   botoes,
  output logic                         ocupado,
  output logic                         pronto,
  output logic                         erro_captura,
  output logic [$clog2(MAX_SEQ+1)-1:0] db_tamanho,
  output logic [3:0]                   db_estado
);

  localparam int AW = (MAX_SEQ > 1) ? $clog2(MAX_SEQ) : 1;
  localparam int CW = $clog2(MAX_SEQ + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

  typedef enum logic [3:0] {
    INATIVO   = 4'd0,
    ESPERA    = 4'd1,
    LED_ON    = 4'd2,
    LED_OFF   = 4'd3,
    PRESSIONA = 4'd4,
    SOLTA     = 4'd5,
    FIM       = 4'd6
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_mem [MAX_SEQ];
  logic [CW-1:0]   r_wr_cnt;
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   w_rd_next;
  logic [HW-1:0]   r_hold;
  logic [GW-1:0]   r_gap;
  logic [QW-1:0]   r_quiet;
  logic            r_erro;
  logic [3:0]      r_botoes;
  logic            w_leds_on;
  logic            w_room;
  logic            w_capture;
  logic            w_overflow;
  logic [AW-1:0]   w_wr_addr;
  logic            w_last;
  logic            w_last_next;
  logic [3:0]      w_mem_val;
  logic [3:0]      w_press_val;

  assign w_leds_on   = |leds;
  assign w_room      = r_wr_cnt < CW'(MAX_SEQ);
  assign w_capture   = !parar && w_leds_on &&
                       (r_state == ESPERA || (r_state == LED_OFF && w_room));
  assign w_overflow  = !parar && w_leds_on && r_state == LED_OFF && !w_room;
  assign w_wr_addr   = (r_state == ESPERA) ? '0 : r_wr_cnt[AW-1:0];
  assign w_last      = (CW'(r_rd) == r_wr_cnt - CW'(1));
  assign w_rd_next   = (r_state == SOLTA)   ? r_rd + AW'(1) :
                       (r_state == LED_OFF) ? '0 : r_rd;
  assign w_last_next = (CW'(w_rd_next) == r_wr_cnt - CW'(1));
  assign w_mem_val   = r_mem[w_rd_next];
  // Error mode corrupts only the final press of the replay.
  assign w_press_val = (modo_erro && w_last_next) ? {w_mem_val[2:0], w_mem_val[3]} : w_mem_val;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= INATIVO;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      INATIVO:   if (iniciar) w_next = ESPERA;
      ESPERA:    if (w_leds_on) w_next = LED_ON;
      LED_ON:    if (!w_leds_on) w_next = LED_OFF;
      LED_OFF: begin
        if (w_leds_on)                             w_next = LED_ON;
        else if (r_quiet == QW'(QUIET_CYCLES - 1)) w_next = PRESSIONA;
      end
      PRESSIONA: if (r_hold == HW'(HOLD_CYCLES - 1)) w_next = SOLTA;
      SOLTA:     if (r_gap == GW'(GAP_CYCLES - 1)) w_next = w_last ? FIM : PRESSIONA;
      FIM:       w_next = ESPERA;
      default:   w_next = INATIVO;
    endcase
    if (parar) w_next = INATIVO;
  end

  always_comb begin
    ocupado   = (r_state != INATIVO);
    pronto    = (r_state == FIM);
    db_estado = r_state;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_cnt <= '0;
      r_rd     <= '0;
      r_hold   <= '0;
      r_gap    <= '0;
      r_quiet  <= '0;
      r_erro   <= 1'b0;
      r_botoes <= 4'b0000;
    end else begin
      if (w_next == ESPERA)  r_wr_cnt <= '0;
      else if (w_capture)    r_wr_cnt <= (r_state == ESPERA) ? CW'(1) : r_wr_cnt + CW'(1);
      if (w_next == ESPERA)  r_erro <= 1'b0;
      else if (w_overflow)   r_erro <= 1'b1;
      if (w_next == PRESSIONA) r_rd <= w_rd_next;
      // Each counter restarts from zero whenever its state is (re)entered.
      r_hold   <= (r_state == PRESSIONA && w_next == PRESSIONA) ? r_hold + HW'(1) : '0;
      r_gap    <= (r_state == SOLTA && w_next == SOLTA) ? r_gap + GW'(1) : '0;
      r_quiet  <= (r_state == LED_OFF && w_next == LED_OFF) ? r_quiet + QW'(1) : '0;
      r_botoes <= (w_next == PRESSIONA) ? w_press_val : 4'b0000;
    end
  end

  always_ff @(posedge clock) begin
    if (w_capture) r_mem[w_wr_addr] <= leds;
  end

  assign botoes       = r_botoes;
  assign erro_captura = r_erro;
  assign db_tamanho   = r_wr_cnt;

endmodule

// File: tb/tb_jogador_automatico.sv
// tb/tb_jogador_automatico.sv - directed table-driven bench for jogador_automatico
module tb_jogador_automatico;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic       parar;
  logic       modo_erro;
  logic [3:0] leds;
  logic [3:0] botoes;
  logic       ocupado;
  logic       pronto;
  logic       erro_captura;
  logic [4:0] db_tamanho;
  logic [3:0] db_estado;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] q_press[$];
  int nz_cycles;

  typedef struct {
    logic       ini;
    logic [3:0] leds;
    int         n;
    logic [3:0] est;
    logic [3:0] b;
    logic [3:0] be;
    logic       pr;
    logic [4:0] tam;
  } vec_t;
  vec_t tv[16];

  jogador_automatico #(
    .MAX_SEQ(16), .HOLD_CYCLES(4), .GAP_CYCLES(2), .QUIET_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .parar(parar),
    .modo_erro(modo_erro), .leds(leds), .botoes(botoes), .ocupado(ocupado),
    .pronto(pronto), .erro_captura(erro_captura), .db_tamanho(db_tamanho),
    .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input logic [3:0] s, input int bound, input string nm);
    for (int i = 0; i < bound && db_estado != s; i++) step();
    chk(nm, db_estado, s);
  endtask

  // Steps through a whole replay, recording each press and the number of nonzero cycles.
  task automatic replay(input string nm);
    logic [3:0] prev;
    logic got;
    q_press.delete();
    nz_cycles = 0;
    prev = 4'b0000;
    got = 1'b0;
    leds = 4'b0000;
    for (int i = 0; i < 3000 && !got; i++) begin
      step();
      if (botoes != 4'b0000) nz_cycles++;
      if (botoes != 4'b0000 && prev == 4'b0000) q_press.push_back(botoes);
      prev = botoes;
      if (pronto) got = 1'b1;
    end
    chk({nm, "_pronto_seen"}, got, 1);
  endtask

  task automatic run_table(input logic modo);
    modo_erro = modo;
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < tv[r].n; k++) begin
        iniciar = tv[r].ini;
        leds    = tv[r].leds;
        step();
        chk($sformatf("m%0d_r%0d_c%0d_estado", modo, r, k), db_estado, tv[r].est);
        chk($sformatf("m%0d_r%0d_c%0d_botoes", modo, r, k), botoes, modo ? tv[r].be : tv[r].b);
        chk($sformatf("m%0d_r%0d_c%0d_pronto", modo, r, k), pronto, tv[r].pr);
        chk($sformatf("m%0d_r%0d_c%0d_tam", modo, r, k), db_tamanho, tv[r].tam);
        chk($sformatf("m%0d_r%0d_c%0d_ocupado", modo, r, k), ocupado, tv[r].est != 4'd0);
      end
    end
    iniciar   = 1'b0;
    modo_erro = 1'b0;
  endtask

  initial begin
    int bad;
    reset = 1'b0; iniciar = 1'b0; parar = 1'b0; modo_erro = 1'b0; leds = 4'b0000;
    //           ini leds  n  est  b     be    pr tam
    tv[0]  = '{1'b1, 4'h0, 1, 4'd1, 4'h0, 4'h0, 1'b0, 5'd0};
    tv[1]  = '{1'b0, 4'h1, 1, 4'd2, 4'h0, 4'h0, 1'b0, 5'd1};
    tv[2]  = '{1'b0, 4'h1, 2, 4'd2, 4'h0, 4'h0, 1'b0, 5'd1};
    tv[3]  = '{1'b0, 4'h0, 1, 4'd3, 4'h0, 4'h0, 1'b0, 5'd1};
    tv[4]  = '{1'b0, 4'h0, 1, 4'd3, 4'h0, 4'h0, 1'b0, 5'd1};
    tv[5]  = '{1'b0, 4'h4, 1, 4'd2, 4'h0, 4'h0, 1'b0, 5'd2};
    tv[6]  = '{1'b0, 4'h4, 2, 4'd2, 4'h0, 4'h0, 1'b0, 5'd2};
    tv[7]  = '{1'b0, 4'h0, 1, 4'd3, 4'h0, 4'h0, 1'b0, 5'd2};
    tv[8]  = '{1'b0, 4'h0, 7, 4'd3, 4'h0, 4'h0, 1'b0, 5'd2};
    tv[9]  = '{1'b0, 4'h0, 1, 4'd4, 4'h1, 4'h1, 1'b0, 5'd2};
    tv[10] = '{1'b0, 4'h0, 3, 4'd4, 4'h1, 4'h1, 1'b0, 5'd2};
    tv[11] = '{1'b0, 4'h0, 2, 4'd5, 4'h0, 4'h0, 1'b0, 5'd2};
    tv[12] = '{1'b0, 4'h0, 4, 4'd4, 4'h4, 4'h8, 1'b0, 5'd2};
    tv[13] = '{1'b0, 4'h0, 2, 4'd5, 4'h0, 4'h0, 1'b0, 5'd2};
    tv[14] = '{1'b0, 4'h0, 1, 4'd6, 4'h0, 4'h0, 1'b1, 5'd2};
    tv[15] = '{1'b0, 4'h0, 1, 4'd1, 4'h0, 4'h0, 1'b0, 5'd0};

    #12;
    chk("rst_botoes", botoes, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_estado", db_estado, 0);
    chk("rst_tam", db_tamanho, 0);
    chk("rst_erro", erro_captura, 0);
    @(negedge clock);
    reset = 1'b1;

    // Basic capture/replay, then the same with the last press corrupted.
    run_table(1'b0);
    parar = 1'b1; step(); parar = 1'b0;
    chk("parar_espera_estado", db_estado, 0);
    run_table(1'b1);

    // Capture overflow: 17 pulses, only 16 stored and replayed.
    for (int p = 0; p < 17; p++) begin
      leds = 4'h2; step();
      leds = 4'h0; step(); step();
      if (p == 16) begin
        chk("ovf_erro", erro_captura, 1);
        chk("ovf_tam", db_tamanho, 16);
      end
    end
    replay("ovf");
    chk("ovf_presses", q_press.size(), 16);
    bad = 0;
    foreach (q_press[i]) if (q_press[i] != 4'h2) bad++;
    chk("ovf_press_values", bad, 0);
    chk("ovf_nz_cycles", nz_cycles, 64);
    chk("ovf_tam_at_fim", db_tamanho, 16);
    step();
    chk("espera_erro_clear", erro_captura, 0);
    chk("espera_tam_clear", db_tamanho, 0);

    // Abort during a press.
    leds = 4'h6; step();
    leds = 4'h0; step();
    wait_state(4'd4, 50, "abort_reach_pressiona");
    step();
    chk("abort_pre_botoes", botoes, 6);
    parar = 1'b1; step(); parar = 1'b0;
    chk("abort_botoes", botoes, 0);
    chk("abort_estado", db_estado, 0);
    chk("abort_ocupado", ocupado, 0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (pronto) bad++;
    end
    chk("abort_no_pronto", bad, 0);

    // iniciar ignored outside INATIVO; a short gap does not start the replay.
    iniciar = 1'b1; step(); iniciar = 1'b0;
    chk("t6_espera", db_estado, 1);
    leds = 4'h3; step();
    leds = 4'h0; step();
    iniciar = 1'b1; step(); iniciar = 1'b0;
    chk("t6_iniciar_ignored", db_estado, 3);
    for (int i = 0; i < 5; i++) step();
    chk("t6_short_gap_estado", db_estado, 3);
    leds = 4'h5; step();
    chk("t6_second_capture_estado", db_estado, 2);
    chk("t6_second_capture_tam", db_tamanho, 2);
    replay("t6");
    chk("t6_presses", q_press.size(), 2);
    if (q_press.size() == 2) begin
      chk("t6_press0", q_press[0], 3);
      chk("t6_press1", q_press[1], 5);
    end
    chk("t6_nz_cycles", nz_cycles, 8);

    // Asynchronous reset in the middle of a press.
    step();
    leds = 4'h9; step();
    leds = 4'h0; step();
    wait_state(4'd4, 50, "t1_reach_pressiona");
    step();
    chk("t1_pre_botoes", botoes, 9);
    #2 reset = 1'b0;
    #1;
    chk("t1_botoes", botoes, 0);
    chk("t1_ocupado", ocupado, 0);
    chk("t1_pronto", pronto, 0);
    chk("t1_estado", db_estado, 0);
    chk("t1_tam", db_tamanho, 0);
    #1 reset = 1'b1;
    step();
    chk("t1_after_estado", db_estado, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
